// File: rtl/wb_hyper_pkg.sv
// Shared definitions for the wb_hyper data-port slice: Wishbone CTI codes,
// arbiter FSM encoding and a small grant-vector helper.
package wb_hyper_pkg;

    localparam logic [2:0] CTI_CLASSIC = 3'b000;
    localparam logic [2:0] CTI_INCR    = 3'b010;
    localparam logic [2:0] CTI_EOB     = 3'b111;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'b00,
        ST_BUSY  = 2'b01,
        ST_ABORT = 2'b10
    } arb_state_e;

    function automatic logic [1:0] owner_onehot(input logic owner);
        logic [1:0] vec;
        if (owner) begin
            vec = 2'b10;
        end else begin
            vec = 2'b01;
        end
        return vec;
    endfunction

endpackage

// File: rtl/wb_ack_watchdog.sv
// Counts consecutive strobe cycles without an acknowledge and pulses expire
// on the last allowed cycle so the arbiter can terminate the transfer.
module wb_ack_watchdog #(
    parameter int TIMEOUT = 255
) (
    input  logic clk,
    input  logic rst_n,
    input  logic cnt_en,
    input  logic clr,
    output logic expire
);

    localparam int CW = $clog2(TIMEOUT + 1);
    localparam logic [CW-1:0] LAST = CW'(TIMEOUT - 1);

    logic [CW-1:0] cnt_r;

    assign expire = cnt_en && (cnt_r == LAST);

    // Stall counter, restarted on ack, on expiry and whenever the bus is not busy.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            cnt_r <= {CW{1'b0}};
        end else if (clr || expire) begin
            cnt_r <= {CW{1'b0}};
        end else if (cnt_en) begin
            cnt_r <= cnt_r + CW'(1);
        end else begin
            cnt_r <= cnt_r;
        end
    end

endmodule

// File: rtl/wb_hyper_arb.sv
// Two-master round-robin Wishbone arbiter in front of the wb_hyper data slave;
// grant is held for a whole bus cycle and a stalled transfer is aborted with err.
module wb_hyper_arb
    import wb_hyper_pkg::*;
#(
    parameter int AW      = 32,
    parameter int DW      = 32,
    parameter int TIMEOUT = 255,
    parameter bit PRIO0   = 1'b0
) (
    input  logic            wb_clk_i,
    input  logic            wb_rst_ni,

    input  logic [AW-1:0]   m0_adr_i,
    input  logic [DW-1:0]   m0_dat_i,
    input  logic [DW/8-1:0] m0_sel_i,
    input  logic [2:0]      m0_cti_i,
    input  logic            m0_we_i,
    input  logic            m0_cyc_i,
    input  logic            m0_stb_i,
    output logic [DW-1:0]   m0_dat_o,
    output logic            m0_ack_o,
    output logic            m0_err_o,

    input  logic [AW-1:0]   m1_adr_i,
    input  logic [DW-1:0]   m1_dat_i,
    input  logic [DW/8-1:0] m1_sel_i,
    input  logic [2:0]      m1_cti_i,
    input  logic            m1_we_i,
    input  logic            m1_cyc_i,
    input  logic            m1_stb_i,
    output logic [DW-1:0]   m1_dat_o,
    output logic            m1_ack_o,
    output logic            m1_err_o,

    output logic [AW-1:0]   s_adr_o,
    output logic [DW-1:0]   s_dat_o,
    output logic [DW/8-1:0] s_sel_o,
    output logic [2:0]      s_cti_o,
    output logic            s_we_o,
    output logic            s_cyc_o,
    output logic            s_stb_o,
    input  logic [DW-1:0]   s_dat_i,
    input  logic            s_ack_i,

    output logic [1:0]      gnt_o
);

    arb_state_e state_r;
    arb_state_e state_nx_s;
    logic       owner_r;
    logic       owner_nx_s;
    logic       rr_last_r;
    logic       rr_last_nx_s;
    logic [1:0] gnt_r;

    logic       own_cyc_s;
    logic       own_stb_s;
    logic       busy_s;
    logic       wd_en_s;
    logic       wd_clr_s;
    logic       wd_expire_s;

    assign busy_s    = (state_r == ST_BUSY);
    assign own_cyc_s = owner_r ? m1_cyc_i : m0_cyc_i;
    assign own_stb_s = owner_r ? m1_stb_i : m0_stb_i;

    // Slave request path follows the registered owner in every state.
    always_comb begin
        s_adr_o = m0_adr_i;
        s_dat_o = m0_dat_i;
        s_sel_o = m0_sel_i;
        s_cti_o = m0_cti_i;
        s_we_o  = m0_we_i;
        if (owner_r) begin
            s_adr_o = m1_adr_i;
            s_dat_o = m1_dat_i;
            s_sel_o = m1_sel_i;
            s_cti_o = m1_cti_i;
            s_we_o  = m1_we_i;
        end else begin
            s_adr_o = m0_adr_i;
            s_dat_o = m0_dat_i;
            s_sel_o = m0_sel_i;
            s_cti_o = m0_cti_i;
            s_we_o  = m0_we_i;
        end
    end

    assign s_cyc_o = busy_s && own_cyc_s;
    assign s_stb_o = busy_s && own_cyc_s && own_stb_s;

    // Ack stays combinational so burst beats pass at slave rate; err needs no ack.
    assign m0_ack_o = busy_s && !owner_r && s_ack_i;
    assign m1_ack_o = busy_s &&  owner_r && s_ack_i;
    assign m0_err_o = wd_expire_s && !owner_r;
    assign m1_err_o = wd_expire_s &&  owner_r;

    assign m0_dat_o = s_dat_i;
    assign m1_dat_o = s_dat_i;

    assign wd_en_s  = busy_s && s_stb_o && !s_ack_i;
    assign wd_clr_s = !busy_s || s_ack_i;

    wb_ack_watchdog #(
        .TIMEOUT (TIMEOUT)
    ) u_watchdog (
        .clk    (wb_clk_i),
        .rst_n  (wb_rst_ni),
        .cnt_en (wd_en_s),
        .clr    (wd_clr_s),
        .expire (wd_expire_s)
    );

    // Arbitration FSM next-state, owner selection and round-robin bookkeeping.
    always_comb begin
        state_nx_s   = state_r;
        owner_nx_s   = owner_r;
        rr_last_nx_s = rr_last_r;
        case (state_r)
            ST_IDLE: begin
                if (m0_cyc_i && m1_cyc_i) begin
                    owner_nx_s = PRIO0 ? 1'b0 : !rr_last_r;
                    state_nx_s = ST_BUSY;
                end else if (m0_cyc_i) begin
                    owner_nx_s = 1'b0;
                    state_nx_s = ST_BUSY;
                end else if (m1_cyc_i) begin
                    owner_nx_s = 1'b1;
                    state_nx_s = ST_BUSY;
                end else begin
                    state_nx_s = ST_IDLE;
                end
            end
            ST_BUSY: begin
                if (!own_cyc_s) begin
                    rr_last_nx_s = owner_r;
                    state_nx_s   = ST_IDLE;
                end else if (wd_expire_s) begin
                    state_nx_s = ST_ABORT;
                end else begin
                    state_nx_s = ST_BUSY;
                end
            end
            ST_ABORT: begin
                if (!own_cyc_s) begin
                    rr_last_nx_s = owner_r;
                    state_nx_s   = ST_IDLE;
                end else begin
                    state_nx_s = ST_ABORT;
                end
            end
            default: begin
                state_nx_s = ST_IDLE;
            end
        endcase
    end

    // State registers; rr_last resets to 1 so master 0 wins the first tie.
    always_ff @(posedge wb_clk_i) begin
        if (!wb_rst_ni) begin
            state_r   <= ST_IDLE;
            owner_r   <= 1'b0;
            rr_last_r <= 1'b1;
            gnt_r     <= 2'b00;
        end else begin
            state_r   <= state_nx_s;
            owner_r   <= owner_nx_s;
            rr_last_r <= rr_last_nx_s;
            if (state_nx_s == ST_IDLE) begin
                gnt_r <= 2'b00;
            end else begin
                gnt_r <= owner_onehot(owner_nx_s);
            end
        end
    end

    assign gnt_o = gnt_r;

endmodule

// File: doc/wb_hyper_arb.md
# wb_hyper_arb

Two-master Wishbone arbiter that shares the single `wb_hyper` data slave port between requesters, e.g. the soft-CPU data bus and the Boson video capture writer. Round-robin grant, held for the whole bus cycle so classic and incrementing bursts (`cti` 3'b010/3'b111) reach the HyperRAM controller unbroken. A per-cycle ack watchdog aborts a stalled transfer with `err` so a hung slave cannot lock out the other master.

## Interface
- `AW`, 32, address width
- `DW`, 32, data width; `sel` width is `DW/8`
- `TIMEOUT`, 255, max cycles with `stb` high and no `ack` before abort (≥2)
- `PRIO0`, 0, 1 = master 0 wins ties from IDLE regardless of round-robin pointer
- `wb_clk_i` in 1: bus clock, all logic on rising edge
- `wb_rst_ni` in 1: reset, synchronous, active-low
- `m0_adr_i`/`m1_adr_i` in AW, `m0_dat_i`/`m1_dat_i` in DW, `m0_sel_i`/`m1_sel_i` in DW/8, `m0_cti_i`/`m1_cti_i` in 3, `m0_we_i`, `m0_cyc_i`, `m0_stb_i` (same for m1) in 1: master requests
- `m0_dat_o`/`m1_dat_o` out DW: read data, `s_dat_i` fanned out to both
- `m0_ack_o`/`m1_ack_o` out 1, `m0_err_o`/`m1_err_o` out 1: per-master termination
- `s_adr_o` out AW, `s_dat_o` out DW, `s_sel_o` out DW/8, `s_cti_o` out 3, `s_we_o`, `s_cyc_o`, `s_stb_o` out 1: to `wb_hyper` data slave
- `s_dat_i` in DW, `s_ack_i` in 1: from slave
- `gnt_o` out 2: one-hot current owner, 2'b00 when idle (debug/status)

## Operation
- FSM states: IDLE, BUSY, ABORT; registers `owner` (1b), `rr_last` (1b), `wd_cnt` (`$clog2(TIMEOUT+1)`b).
- IDLE: no request → stay. One `mX_cyc_i` high → `owner`=X, go BUSY. Both high → `owner` = !`rr_last` (or 0 if `PRIO0`), go BUSY.
- BUSY: slave outputs = owner's inputs, combinational mux on registered `owner`. `s_ack_i` routed to owner's `ack_o` only; other master's ack/err 0. Non-owner requests ignored (held pending).
- BUSY → IDLE when owner's `cyc_i` low; `rr_last` ← `owner` at that transition.
- Watchdog: `wd_cnt` increments each BUSY cycle with `s_stb_o`=1 and `s_ack_i`=0; clears on ack or leaving BUSY. At `wd_cnt`==TIMEOUT-1 with no ack: owner's `err_o`=1 for exactly that cycle, go ABORT.
- ABORT: `s_cyc_o`=`s_stb_o`=0, no ack/err; stay until owner's `cyc_i` low, then IDLE, `rr_last` ← `owner`.
- `s_cyc_o`/`s_stb_o` forced 0 in IDLE and ABORT; other slave outputs don't-care there (drive owner mux).
- Ack and err never asserted in the same cycle; ack wins if `s_ack_i` arrives on the timeout cycle.

## Timing
- Reset (`wb_rst_ni`=0 at clock edge): state IDLE, `owner`=0, `rr_last`=1 (so m0 first), `wd_cnt`=0; all `*_ack_o`, `*_err_o`, `s_cyc_o`, `s_stb_o`, `gnt_o` = 0. Reset mid-transfer drops `s_cyc_o` next cycle; no ack delivered.
- Grant latency: `cyc` seen in IDLE at edge N → `s_cyc_o` high during cycle N+1.
- Handover: minimum one IDLE cycle between owners (guarantees `wb_hyper` deasserts CS between transactions).
- Ack path combinational (`s_ack_i` → `mX_ack_o`), zero added latency; burst beats pass at slave rate.
- Owner dropping `cyc` while `s_ack_i` high: ack still forwarded that cycle, then IDLE.
- Starvation bound: a pending master is granted right after the current owner's cycle ends (PRIO0=0).

## Structure
- Shared package `wb_hyper_pkg`: CTI constants (CLASSIC 3'b000, INCR 3'b010, EOB 3'b111) and FSM state encoding, reused by `wb_hyper`.
- Single module; watchdog counter optionally split as sub-module `wb_ack_watchdog` (count enable, clear, expire pulse).

## Test plan
- Single m0 write 32'h12345678 @0x0 → `s_cyc_o` one cycle after `m0_cyc_i`, `m0_ack_o` mirrors `s_ack_i`, `m1_ack_o` stays 0; read back 32'h12345678 on `m0_dat_o`.
- Simultaneous m0/m1 single reads after reset → m0 first, m1 granted after ≥1 IDLE cycle; next simultaneous pair → m1 first (round-robin).
- m0 4-beat INCR burst 01020304..0d0e0f00 while m1 requests mid-burst → all 4 beats to m0 uninterrupted, m1 granted only after m0 drops `cyc`.
- Slave model never acks, TIMEOUT=8 → `m0_err_o` single pulse 8 cycles after `stb`, `s_cyc_o` low next cycle, FSM in ABORT until `m0_cyc_i` low.
- `wb_rst_ni` low during m1 burst beat 2 → next cycle `s_cyc_o`=0, `gnt_o`=0, no further acks; post-reset request granted normally.
- `s_ack_i` arriving on exact timeout cycle → ack delivered, no err, stays BUSY.
